fredkin_jk_counter: RTL
=======================

Name: fredkin_jk_counter

Overview:
- Synchronous mod-MODULUS counter built from a bank of JK flip-flop cells with reversible (Fredkin) steering logic.
- Downstream consumer of the JK flip-flop stage: derives per-bit J/K drive from the current count, load and enable, and produces q/qb plus a terminal-count strobe.
- Serves as the first multi-bit sequential block in the reversible-logic library, driving dividers and sequencers.

Parameters:
- WIDTH, 4, counter bit width; must satisfy 2^WIDTH >= MODULUS.
- MODULUS, 10, count sequence is 0..MODULUS-1; legal range 2..2^WIDTH.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  synchronous active-high reset.
- en  input  1  count enable.
- load  input  1  parallel load strobe.
- din  input  WIDTH  parallel load value.
- q  output  WIDTH  current count.
- qb  output  WIDTH  bitwise complement of q, registered alongside q.
- tc  output  1  terminal count; combinational.

Behaviour:
- Interface: one clock `clk`; reset `rst` is synchronous and active-high.
- Reset: on a clk edge with rst=1, q=0 and qb=all ones. tc=0 while q=0 in up mode.
- Priority per edge is rst > load > en > hold.
- Load: the next q is din when din < MODULUS. When din >= MODULUS, the next q is 0; this is defined behaviour, not X.
  - Implemented as J=din[i], K=~din[i] per cell.
  - en is ignored in a load cycle.
- Count (en=1, load=0): the next q is q+1 when q < MODULUS-1, and 0 when q = MODULUS-1 (wrap). One-cycle latency.
- Per-bit toggle term: T[i] = en AND q[0] AND … AND q[i-1], formed as a chain of Fredkin AND (control=q[k], second input tied 0).
  - The wrap term forces J=0, K=1 on every bit.
  - Each cell gets J=K=T[i] except when wrap or load overrides.
- Hold (en=0, load=0): J=K=0 on all cells; q is unchanged.
- tc = en AND (q == MODULUS-1). It is high in the cycle before the wrap edge, so it can cascade into a next stage's en.
- Invariant at every edge after reset: qb == ~q. An X on q/qb after the first reset edge is a failure.
- Reset asserted mid-count overrides load/en in that cycle; counting resumes from 0 on the first edge after rst deasserts.
- MODULUS = 2^WIDTH: no wrap compare is needed; natural rollover is used and must give the same sequence.

Optional Feature:
- Macro: FREDKIN_UPDOWN_EN.
- When defined: adds input `up` (1 bit).
  - up=1 behaves as above.
  - up=0 decrements: next q = q-1, and 0 wraps to MODULUS-1.
  - Down toggle chain uses qb[k] in place of q[k].
  - tc = en AND (q == 0) when up=0.
  - up is sampled on the same edge as en.
- When undefined: no `up` port; up-count only; no down-chain gates are generated.

Decomposition:
- Shared package/include `fredkin_defs`: Fredkin gate select encodings, the tie-0/tie-1 constants used to configure Fredkin gates as AND/OR/NOT, and a macro for the MODULUS-1 compare width.
- One sub-module, `fredkin_jk_cell`: a single JK bit with synchronous rst.
  - Inputs: clk, rst, j, k.
  - Outputs: q, qb.
  - Instantiated WIDTH times by generate.
- Toggle chain, wrap detect and load steering stay in the top level.

Test Plan:
- Reset: rst=1 for 2 cycles, then rst=0, en=0 -> q=0, qb=4'hF, tc=0, held for 5 cycles.
- Count and wrap: WIDTH=4, MODULUS=10, en=1 for 12 cycles -> q goes 1..9, 0, 1, 2; tc=1 exactly while q=9.
- Load: load=1, din=7 with en=1 -> q=7 next cycle; then en=1 -> q=8, 9, 0. Also load din=12 -> q=0.
- Enable gating: q=5, en toggling 1,0,0,1 -> q=6,6,6,7; tc=0 throughout.
- Reset mid-operation: q=8, rst=1 and load=1, din=3 in the same cycle -> q=0, qb=4'hF; the following edge with en=1 -> q=1.
- Up/down (FREDKIN_UPDOWN_EN defined): q=1, up=0, en=1 -> q=0, then q=9 with tc=1 while q=0. Random mix of up, en and load against a reference model, checking qb==~q every edge.

Source files
------------

// File: rtl/fredkin_defs.sv
// fredkin_defs
//   Shared definitions for the reversible-logic library.
//   A Fredkin gate is a controlled swap: with control c low the data inputs
//   pass straight through (x=a, y=b); with c high they swap (x=b, y=a).
//   Tying one data input to a constant turns the gate into AND, OR or NOT.
//   Also provides FREDKIN_CMP_W(m), the bit width needed to hold m-1, used
//   for the terminal-count compare constant.

`ifndef FREDKIN_DEFS_MACROS
`define FREDKIN_DEFS_MACROS
`define FREDKIN_CMP_W(m) (((m) > 2) ? $clog2(m) : 1)
`endif

package fredkin_defs;

  // Which classical function a Fredkin gate is configured to perform
  typedef enum logic [1:0] {
    FK_AND  = 2'd0,
    FK_OR   = 2'd1,
    FK_NOT  = 2'd2,
    FK_PASS = 2'd3
  } fk_sel_e;

  // Constant ties used on the spare data input of a configured gate
  localparam logic TIE0 = 1'b0;
  localparam logic TIE1 = 1'b1;

  // First data output of a Fredkin gate (the control passes through unchanged)
  function automatic logic fredkin_x(input logic c, input logic a, input logic b);
    return c ? b : a;
  endfunction

  // Second data output of a Fredkin gate
  function automatic logic fredkin_y(input logic c, input logic a, input logic b);
    return c ? a : b;
  endfunction

  // Fredkin gate wired up as a two-input (or one-input) classical gate.
  //   AND : y with b tied 0   -> c & a
  //   OR  : x with b tied 1   -> c | a
  //   NOT : y with a=0, b=1   -> ~c
  //   PASS: x with c tied 0   -> a
  function automatic logic fredkin_gate(input fk_sel_e sel, input logic c, input logic a);
    logic r;
    r = 1'b0;
    case (sel)
      FK_AND:  r = fredkin_y(c, a, TIE0);
      FK_OR:   r = fredkin_x(c, a, TIE1);
      FK_NOT:  r = fredkin_y(c, TIE0, TIE1);
      FK_PASS: r = fredkin_x(TIE0, a, c);
      default: r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/fredkin_jk_cell.sv
// fredkin_jk_cell
//   One JK flip-flop bit with synchronous active-high reset.
//   q and qb are kept as two separate registers so the complement is a true
//   registered output rather than an inverter on q.
// Ports:
//   clk  - clock, rising edge
//   rst  - synchronous reset: q=0, qb=1
//   j,k  - JK drive: 00 hold, 01 clear, 10 set, 11 toggle
//   q,qb - stored bit and its complement

module fredkin_jk_cell (
  input  logic clk,
  input  logic rst,
  input  logic j,
  input  logic k,
  output logic q,
  output logic qb
);

  // Classic JK next-state behaviour, with reset taking priority
  always_ff @(posedge clk) begin
    if (rst) begin
      q  <= 1'b0;
      qb <= 1'b1;
    end else begin
      case ({j, k})
        2'b01:   begin q <= 1'b0; qb <= 1'b1; end
        2'b10:   begin q <= 1'b1; qb <= 1'b0; end
        2'b11:   begin q <= qb;   qb <= q;    end
        default: begin q <= q;    qb <= qb;   end
      endcase
    end
  end

endmodule

// File: rtl/fredkin_jk_counter.sv
// fredkin_jk_counter
//   Synchronous mod-MODULUS counter built from WIDTH JK cells whose J/K drive
//   is steered by Fredkin-gate logic. Priority per edge: rst > load > en > hold.
//   Optional macro FREDKIN_UPDOWN_EN adds an `up` input for down counting.
// Parameters:
//   WIDTH   - counter width, 2**WIDTH >= MODULUS
//   MODULUS - count sequence is 0..MODULUS-1
// Ports:
//   clk  - clock, rising edge
//   up   - (FREDKIN_UPDOWN_EN only) 1 = count up, 0 = count down
//   rst  - synchronous active-high reset
//   en   - count enable
//   load - parallel load strobe (out-of-range din loads 0)
//   din  - parallel load value
//   q    - current count
//   qb   - registered complement of q
//   tc   - combinational terminal count, high the cycle before a wrap

module fredkin_jk_counter
  import fredkin_defs::*;
#(
  parameter int WIDTH   = 4,
  parameter int MODULUS = 10
) (
  input  logic             clk,
`ifdef FREDKIN_UPDOWN_EN
  input  logic             up,
`endif
  input  logic             rst,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qb,
  output logic             tc
);

  localparam int                CMPW    = `FREDKIN_CMP_W(MODULUS);
  localparam logic [CMPW-1:0]   LAST_N  = CMPW'(MODULUS - 1);
  localparam logic [WIDTH-1:0]  LAST    = WIDTH'(LAST_N);
  localparam logic [WIDTH:0]    MOD_EXT = (WIDTH + 1)'(MODULUS);
  localparam bit                POW2    = (MODULUS == (1 << WIDTH));

  logic [WIDTH-1:0] j, k;
  logic [WIDTH-1:0] tUp;
  logic [WIDTH-1:0] ldVal;
  logic             atLast;
  logic             wrapUp;

  // Up toggle chain: bit i toggles when en and all lower bits are 1
  assign tUp[0] = en;
  for (genvar i = 1; i < WIDTH; i++) begin : g_up_chain
    assign tUp[i] = fredkin_gate(FK_AND, q[i-1], tUp[i-1]);
  end

  assign atLast = (q == LAST);

  // A full power-of-two range rolls over naturally, so no wrap steering
  if (POW2) begin : g_up_nowrap
    assign wrapUp = 1'b0;
  end else begin : g_up_wrap
    assign wrapUp = en & atLast;
  end

  // Out-of-range load values collapse to 0
  assign ldVal = ({1'b0, din} < MOD_EXT) ? din : '0;

`ifdef FREDKIN_UPDOWN_EN
  logic [WIDTH-1:0] tDn;
  logic             atZero;
  logic             wrapDn;

  // Down toggle chain: bit i toggles when en and all lower bits are 0
  assign tDn[0] = en;
  for (genvar i = 1; i < WIDTH; i++) begin : g_dn_chain
    assign tDn[i] = fredkin_gate(FK_AND, qb[i-1], tDn[i-1]);
  end

  assign atZero = (q == '0);

  if (POW2) begin : g_dn_nowrap
    assign wrapDn = 1'b0;
  end else begin : g_dn_wrap
    assign wrapDn = en & atZero;
  end

  // Per-cell J/K steering: load forces the value, wraps force the endpoint
  always_comb begin
    j = '0;
    k = '0;
    if (load) begin
      j = ldVal;
      k = ~ldVal;
    end else if (up) begin
      if (wrapUp) begin
        j = '0;
        k = '1;
      end else begin
        j = tUp;
        k = tUp;
      end
    end else begin
      if (wrapDn) begin
        j = LAST;
        k = ~LAST;
      end else begin
        j = tDn;
        k = tDn;
      end
    end
  end

  assign tc = up ? (en & atLast) : (en & atZero);
`else
  // Per-cell J/K steering: load forces the value, wrap clears every bit
  always_comb begin
    j = '0;
    k = '0;
    if (load) begin
      j = ldVal;
      k = ~ldVal;
    end else if (wrapUp) begin
      j = '0;
      k = '1;
    end else begin
      j = tUp;
      k = tUp;
    end
  end

  assign tc = en & atLast;
`endif

  for (genvar i = 0; i < WIDTH; i++) begin : g_cells
    fredkin_jk_cell u_cell (
      .clk (clk),
      .rst (rst),
      .j   (j[i]),
      .k   (k[i]),
      .q   (q[i]),
      .qb  (qb[i])
    );
  end

endmodule
